// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Prescaled scan, anti-ghost blanking, leading-zero suppression, frame-aligned loads.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] stage_val_q, stage_val_d;
    logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    pending_q, pending_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tick;
    logic                    frame;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    lz_run;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [3:0]              nib;
    logic                    en_sel;
    logic                    dp_sel;
    logic                    lz_sel;
    logic                    slot_blank;
    logic [6:0]              seg_on;
    logic                    dp_on;

    // Active-high abcdefg pattern for one hex nibble (bit 0 = a)
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Prescaler and scan index; the last tick of the last digit closes a frame
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        frame   = tick && (idx_q == IDX_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Staging/shadow: loads wait for a frame boundary so a frame never tears
    always_comb begin
        stage_val_d  = stage_val_q;
        stage_dp_d   = stage_dp_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        if (load) begin
            stage_val_d = value_in;
            stage_dp_d  = dp_in;
        end
        if (frame) begin
            pending_d = 1'b0;
            if (load) begin
                shadow_val_d = value_in;
                shadow_dp_d  = dp_in;
            end else if (pending_q) begin
                shadow_val_d = stage_val_q;
                shadow_dp_d  = stage_dp_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Slot output: blanking window, digit select, suppression, polarity
    always_comb begin
        lz_run  = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run && (shadow_val_q[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_run && (i > 0);
        end

        an_sel = '0;
        nib    = 4'h0;
        en_sel = 1'b0;
        dp_sel = 1'b0;
        lz_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(idx_q) == i) begin
                an_sel[i] = 1'b1;
                nib       = shadow_val_q[4*i +: 4];
                en_sel    = digit_en[i];
                dp_sel    = shadow_dp_q[i];
                lz_sel    = lz_mask[i];
            end
        end

        slot_blank = (int'(presc_q) < BLANK_CYC);
        seg_on     = hex_to_seg(nib);
        dp_on      = dp_sel;
        if (!en_sel || (lz_blank && lz_sel)) begin
            seg_on = '0;
            dp_on  = 1'b0;
        end
        if (slot_blank) begin
            seg_on = '0;
            dp_on  = 1'b0;
            an_sel = '0;
        end

        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_on : dp_on;
        an_d  = (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
    end

    // State and output registers; reset drops any pending load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            stage_val_q  <= '0;
            stage_dp_q   <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            stage_val_q  <= stage_val_d;
            stage_dp_q   <= stage_dp_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_done = frame;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: 4 digits, CLK_DIV=4, BLANK_CYC=1.
// Stimulus queues expected frames; a monitor checks every output cycle.
module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS    (4),
        .CLK_DIV       (4),
        .BLANK_CYC     (1),
        .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .lz_blank  (lz_blank),
        .load      (load),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .pending   (pending),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [31:0]     frame_no;
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    bit   have_cur;
    int   cyc;
    int   n_checks;
    int   n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)",
                      name, act, exp, cyc, $time);
    endtask

    task automatic push(input int f, input logic [6:0] s3, input logic [6:0] s2,
                        input logic [6:0] s1, input logic [6:0] s0,
                        input logic [3:0] d);
        exp_t e;
        e.frame_no = f;
        e.seg      = {s3, s2, s1, s0};
        e.dp       = d;
        sbq.push_back(e);
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: cycle-exact scan timing, queued frame contents
    always @(negedge clk) begin
        int n, f, slot, p;
        logic [3:0] ae;
        if (!rst_n) begin
            have_cur = 1'b0;
        end else begin
            n = cyc;
            check("frame_done", {31'b0, frame_done}, {31'b0, (n % 16) == 15});
            if (n == 0) begin
                check("an_rel", {28'b0, an}, 32'hF);
            end else begin
                f    = (n - 1) / 16;
                slot = ((n - 1) / 4) % 4;
                p    = (n - 1) % 4;
                if ((n - 1) % 16 == 0) begin
                    have_cur = 1'b0;
                    while (sbq.size() > 0 && int'(sbq[0].frame_no) < f) begin
                        check("sb_stale", sbq[0].frame_no, f);
                        void'(sbq.pop_front());
                    end
                    if (sbq.size() > 0 && int'(sbq[0].frame_no) == f) begin
                        cur      = sbq.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (p == 0) begin
                    check("an_blank", {28'b0, an}, 32'hF);
                    check("seg_blank", {25'b0, seg}, 32'h7F);
                    check("dp_blank", {31'b0, dp}, 32'h1);
                end else begin
                    ae = ~(4'b0001 << slot);
                    check("an_slot", {28'b0, an}, {28'b0, ae});
                    if (have_cur) begin
                        check("seg", {25'b0, seg}, {25'b0, cur.seg[slot]});
                        check("dp", {31'b0, dp}, {31'b0, cur.dp[slot]});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        value_in = '0;
        dp_in    = '0;
        digit_en = 4'hF;
        lz_blank = 1'b0;
        load     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", {28'b0, an}, 32'hF);
        check("rst_seg", {25'b0, seg}, 32'h7F);
        check("rst_dp", {31'b0, dp}, 32'h1);
        check("rst_pending", {31'b0, pending}, 32'h0);
        check("rst_frame_done", {31'b0, frame_done}, 32'h0);

        // 1: free-running scan of zeros
        push(0, 7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
        push(1, 7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
        push(2, 7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
        rst_n = 1'b1;

        // 2: mid-frame load, visible only from frame 3
        goto(40);
        load     = 1'b1;
        value_in = 16'h1A5F;
        dp_in    = 4'b0010;
        push(3, 7'h79, 7'h08, 7'h12, 7'h0E, 4'b1101);
        @(negedge clk);
        load = 1'b0;
        check("pend_set", {31'b0, pending}, 32'h1);
        goto(47);
        check("pend_hold", {31'b0, pending}, 32'h1);
        goto(48);
        check("pend_clr", {31'b0, pending}, 32'h0);

        // 3: two loads in one frame, last wins
        goto(50);
        load     = 1'b1;
        value_in = 16'h1111;
        dp_in    = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        goto(55);
        load     = 1'b1;
        value_in = 16'h2222;
        push(4, 7'h24, 7'h24, 7'h24, 7'h24, 4'hF);
        @(negedge clk);
        load = 1'b0;
        check("pend_two", {31'b0, pending}, 32'h1);
        goto(64);
        check("pend_two_clr", {31'b0, pending}, 32'h0);

        // 4: load on the boundary cycle goes straight to shadow
        goto(79);
        check("fd_boundary", {31'b0, frame_done}, 32'h1);
        load     = 1'b1;
        value_in = 16'h00C3;
        lz_blank = 1'b1;
        push(5, 7'h7F, 7'h7F, 7'h46, 7'h30, 4'hF);
        push(6, 7'h7F, 7'h7F, 7'h46, 7'h30, 4'hF);
        @(negedge clk);
        load = 1'b0;
        check("pend_direct", {31'b0, pending}, 32'h0);
        goto(85);
        check("pend_direct2", {31'b0, pending}, 32'h0);

        // 5: enables plus leading-zero suppression on 0000
        goto(98);
        load     = 1'b1;
        value_in = 16'h0000;
        dp_in    = 4'b0101;
        @(negedge clk);
        load = 1'b0;
        goto(112);
        digit_en = 4'b1011;
        push(7, 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1110);
        push(8, 7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1110);

        // 6: async reset mid-slot with a load pending
        goto(130);
        load     = 1'b1;
        value_in = 16'h4321;
        dp_in    = 4'hF;
        @(negedge clk);
        load = 1'b0;
        check("pend_pre_rst", {31'b0, pending}, 32'h1);
        goto(134);
        rst_n = 1'b0;
        #1;
        check("arst_an", {28'b0, an}, 32'hF);
        check("arst_seg", {25'b0, seg}, 32'h7F);
        check("arst_dp", {31'b0, dp}, 32'h1);
        check("arst_pending", {31'b0, pending}, 32'h0);
        sbq.delete();
        digit_en = 4'hF;
        lz_blank = 1'b0;
        repeat (2) @(negedge clk);
        push(0, 7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
        push(1, 7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
        rst_n = 1'b1;
        goto(40);
        check("sb_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
